// File: rtl/pc_defs.sv
// Shared definitions for the next-PC sequencer: PC width, sequencer states,
// default vectors and the alignment helper used on branch/jump targets.
package pc_defs;

  localparam int PC_W        = 16;
  localparam int STALL_CNT_W = 8;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam pc_t                    RESET_VEC_DEF     = 16'h0000;
  localparam pc_t                    TRAP_VEC_DEF      = 16'h0010;
  localparam pc_t                    PC_STEP_DEF       = 16'd2;
  localparam logic [STALL_CNT_W-1:0] STALL_TIMEOUT_DEF = 8'd255;

  function automatic pc_t align_pc(input pc_t addr);
    return {addr[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_stall_counter.sv
// Saturating count of consecutive stall cycles with a sticky timeout flag
// that sets on the increment that reaches TIMEOUT.
module pc_stall_counter
  import pc_defs::*;
#(
  parameter logic [STALL_CNT_W-1:0] TIMEOUT = STALL_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clear,
  output logic timeout
);

  logic [STALL_CNT_W-1:0] count;
  logic [STALL_CNT_W-1:0] count_inc;

  assign count_inc = (count == '1) ? count : count + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      timeout <= 1'b0;
    end else begin
      // NOTE: state is updated with <= so every register samples pre-edge values.
      if (clear) begin
        count <= '0;
      end else if (inc) begin
        count <= count_inc;
        if (count_inc >= TIMEOUT) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot vector, sequential fetch, branch/jump redirect, stall and halt.
// Optional trap redirect (external request or misaligned target) is built with PCSEQ_TRAP_EN.
module pc_sequencer
  import pc_defs::*;
#(
  parameter pc_t                    RESET_VEC     = RESET_VEC_DEF,
  parameter pc_t                    PC_STEP       = PC_STEP_DEF,
  parameter logic [STALL_CNT_W-1:0] STALL_TIMEOUT = STALL_TIMEOUT_DEF,
  parameter pc_t                    TRAP_VEC      = TRAP_VEC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  pc_t  pc_cur,
  input  logic stall,
  input  logic branch_taken,
  input  pc_t  branch_target,
  input  logic jump,
  input  pc_t  jump_target,
  input  logic halt,
  input  logic resume,
  input  logic trap_req,
  output logic PCWrite,
  output pc_t  PCin,
  output logic flush,
  output logic halted,
  output logic stall_timeout,
  output pc_t  epc
);

  pc_state_e state;
  pc_state_e state_next;
  logic      redirect;
  logic      stall_inc;

  logic      sel_valid;
  pc_t       sel_target;
  logic      redir_req;
  pc_t       redir_pc;

`ifdef PCSEQ_TRAP_EN
  logic redir_trap;
  pc_t  redir_epc;
  pc_t  epc_q;
  pc_t  epc_next;
`endif

  // Branch beats jump; with traps built in, a trap request or odd target
  // diverts to the handler instead of being silently aligned.
  always_comb begin
    sel_valid  = branch_taken | jump;
    sel_target = branch_taken ? branch_target : jump_target;
    redir_req  = sel_valid;
    redir_pc   = align_pc(sel_target);
`ifdef PCSEQ_TRAP_EN
    redir_trap = 1'b0;
    redir_epc  = pc_cur;
    if (trap_req) begin
      redir_req  = 1'b1;
      redir_trap = 1'b1;
      redir_pc   = TRAP_VEC;
      redir_epc  = pc_cur;
    end else if (sel_valid && sel_target[0]) begin
      redir_trap = 1'b1;
      redir_pc   = TRAP_VEC;
      redir_epc  = align_pc(sel_target);
    end
`endif
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    PCWrite    = 1'b0;
    PCin       = RESET_VEC;
    state_next = state;
    redirect   = 1'b0;
    stall_inc  = 1'b0;
`ifdef PCSEQ_TRAP_EN
    epc_next   = epc_q;
`endif
    if (reset) begin
      case (state)
        ST_BOOT: begin
          PCWrite    = 1'b1;
          PCin       = RESET_VEC;
          state_next = ST_RUN;
        end
        ST_RUN: begin
          if (redir_req) begin
            PCWrite  = 1'b1;
            PCin     = redir_pc;
            redirect = 1'b1;
`ifdef PCSEQ_TRAP_EN
            if (redir_trap) epc_next = redir_epc;
`endif
          end else if (halt) begin
            state_next = ST_HALT;
          end else if (stall) begin
            stall_inc = 1'b1;
          end else begin
            PCWrite = 1'b1;
            PCin    = pc_cur + PC_STEP;
          end
        end
        ST_HALT: begin
`ifdef PCSEQ_TRAP_EN
          if (trap_req) begin
            PCWrite    = 1'b1;
            PCin       = TRAP_VEC;
            redirect   = 1'b1;
            epc_next   = pc_cur;
            state_next = ST_RUN;
          end else
`endif
          if (resume && !halt) state_next = ST_RUN;
        end
        default: state_next = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_BOOT;
      flush  <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      flush  <= redirect;
      halted <= (state_next == ST_HALT);
    end
  end

  pc_stall_counter #(
    .TIMEOUT(STALL_TIMEOUT)
  ) u_stall_counter (
    .clk    (clk),
    .rst_n  (reset),
    .inc    (stall_inc),
    .clear  (~stall_inc),
    .timeout(stall_timeout)
  );

`ifdef PCSEQ_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) epc_q <= '0;
    else        epc_q <= epc_next;
  end

  assign epc = epc_q;
`else
  logic unused_trap;
  assign unused_trap = &{1'b0, trap_req, TRAP_VEC, sel_target[0]};
  assign epc = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised bench for pc_sequencer with a behavioural next-PC model, a per-cycle
// compare process and directed scenarios pinned by literal expectations.
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam logic [15:0] RV   = 16'h0100;
  localparam logic [15:0] TV   = 16'h0010;
  localparam logic [15:0] STEP = 16'd2;
  localparam int          TO   = 255;
`ifdef PCSEQ_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc_cur = '0;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [15:0] branch_target = '0, jump_target = '0;
  logic        halt = 1'b0, resume = 1'b0, trap_req = 1'b0;
  logic        PCWrite, flush, halted, stall_timeout;
  logic [15:0] PCin, epc;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .RESET_VEC(RV), .PC_STEP(STEP), .STALL_TIMEOUT(8'd255), .TRAP_VEC(TV)
  ) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .halt(halt), .resume(resume),
    .trap_req(trap_req), .PCWrite(PCWrite), .PCin(PCin), .flush(flush),
    .halted(halted), .stall_timeout(stall_timeout), .epc(epc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one PC register plus a few flags describing the sequencer.
  logic [15:0] pc_reg = '0;
  bit          m_boot = 1'b1, m_halt = 1'b0, m_flush = 1'b0, m_to = 1'b0;
  int          m_stalls = 0;
  logic [15:0] m_epc = '0;

  task automatic model_cycle();
    bit exp_we, nf, nh, stalled, have;
    logic [15:0] exp_pc, n_epc, t;
    if (!reset) begin
      check("rst_pcwrite", PCWrite, 0);
      check("rst_pcin", PCin, RV);
      check("rst_flush", flush, 0);
      check("rst_halted", halted, 0);
      check("rst_timeout", stall_timeout, 0);
      check("rst_epc", epc, 0);
      m_boot = 1; m_halt = 0; m_flush = 0; m_to = 0; m_stalls = 0; m_epc = '0;
      return;
    end
    exp_we = 0; exp_pc = '0; nf = 0; nh = m_halt; stalled = 0; n_epc = m_epc; have = 0;
    if (m_boot) begin
      exp_we = 1; exp_pc = RV;
    end else if (m_halt) begin
      if (TRAP_ON && trap_req) begin
        exp_we = 1; exp_pc = TV; nf = 1; nh = 0; n_epc = pc_cur;
      end else if (resume && !halt) begin
        nh = 0;
      end
    end else begin
      if (TRAP_ON && trap_req) begin
        have = 1; exp_pc = TV; n_epc = pc_cur;
      end else if (branch_taken || jump) begin
        t = branch_taken ? branch_target : jump_target;
        have = 1;
        if (TRAP_ON && t[0]) begin
          exp_pc = TV; n_epc = t & 16'hFFFE;
        end else begin
          exp_pc = t & 16'hFFFE;
        end
      end
      if (have) begin
        exp_we = 1; nf = 1;
      end else if (halt) begin
        nh = 1;
      end else if (stall) begin
        stalled = 1;
      end else begin
        exp_we = 1; exp_pc = pc_cur + STEP;
      end
    end
    check("pcwrite", PCWrite, exp_we);
    if (exp_we) check("pcin", PCin, exp_pc);
    check("flush", flush, m_flush);
    check("halted", halted, m_halt);
    check("stall_timeout", stall_timeout, m_to);
    check("epc", epc, m_epc);
    m_boot = 0; m_halt = nh; m_flush = nf; m_epc = n_epc;
    if (stalled) begin
      m_stalls = (m_stalls < 255) ? m_stalls + 1 : 255;
      if (m_stalls >= TO) m_to = 1;
    end else begin
      m_stalls = 0;
    end
    if (exp_we) pc_reg = exp_pc;
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      #2;
      model_cycle();
    end
  end

  // Staged stimulus: tests fill s, tick() applies it for one cycle then returns to idle.
  typedef struct packed {
    logic        stall, br;
    logic [15:0] bt;
    logic        jp;
    logic [15:0] jt;
    logic        hl, rs, tr, pc_en;
    logic [15:0] pc;
  } stim_t;

  stim_t s = '0;
  logic  rst_lvl = 1'b0;

  task automatic tick();
    @(negedge clk);
    reset         = rst_lvl;
    stall         = s.stall;
    branch_taken  = s.br;
    branch_target = s.bt;
    jump          = s.jp;
    jump_target   = s.jt;
    halt          = s.hl;
    resume        = s.rs;
    trap_req      = s.tr;
    pc_cur        = s.pc_en ? s.pc : pc_reg;
    s = '0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_lvl = 1'b0;
    reset   = 1'b0;
    #1;
    check("async_pcwrite", PCWrite, 0);
    check("async_pcin", PCin, RV);
    check("async_halted", halted, 0);
    check("async_flush", flush, 0);
    check("async_timeout", stall_timeout, 0);
  endtask

  initial begin : stimulus
    // Reset, boot and sequential fetch.
    repeat (3) tick();
    #3 check("hold_pcwrite", PCWrite, 0);
    rst_lvl = 1'b1;
    tick(); #3 check("boot_pcin", PCin, 16'h0100); check("boot_we", PCWrite, 1);
    tick(); #3 check("seq1_pcin", PCin, 16'h0102);
    tick(); #3 check("seq2_pcin", PCin, 16'h0104);

    // Branch overrides stall; branch beats jump.
    s.pc_en = 1; s.pc = 16'h0200; s.stall = 1; s.br = 1; s.bt = 16'h0400;
    tick(); #3 check("br_pcin", PCin, 16'h0400); check("br_we", PCWrite, 1);
    tick(); #3 check("br_flush", flush, 1); check("after_br_pcin", PCin, 16'h0402);
    s.br = 1; s.bt = 16'h0500; s.jp = 1; s.jt = 16'h0600;
    tick(); #3 check("br_over_jmp", PCin, 16'h0500);

    // Long stall reaches timeout; flag stays after stall drops.
    for (int i = 0; i < 255; i++) begin
      s.stall = 1;
      tick(); #3 check("stall_hold", PCWrite, 0);
    end
    tick(); #3 check("timeout_set", stall_timeout, 1); check("unstall_we", PCWrite, 1);
    tick(); #3 check("timeout_sticky", stall_timeout, 1);

    // Halt, ignored jump, halt+resume, resume.
    s.hl = 1;
    tick(); #3 check("halt_we", PCWrite, 0);
    s.jp = 1; s.jt = 16'h0700;
    tick(); #3 check("halt_jmp_we", PCWrite, 0); check("halted_on", halted, 1);
    s.hl = 1; s.rs = 1;
    tick();
    s.rs = 1;
    tick(); #3 check("resume_we", PCWrite, 0); check("resume_halted", halted, 1);
    s.pc_en = 1; s.pc = 16'h0800;
    tick(); #3 check("resumed_halted", halted, 0); check("resumed_pcin", PCin, 16'h0802);

    // Wrap and odd jump target.
    s.pc_en = 1; s.pc = 16'hFFFE;
    tick(); #3 check("wrap_pcin", PCin, 16'h0000);
    s.jp = 1; s.jt = 16'h0301;
`ifdef PCSEQ_TRAP_EN
    tick(); #3 check("misalign_pcin", PCin, 16'h0010);
    tick(); #3 check("misalign_epc", epc, 16'h0300); check("misalign_flush", flush, 1);
`else
    tick(); #3 check("align_pcin", PCin, 16'h0300);
    tick(); #3 check("align_epc", epc, 16'h0000); check("align_flush", flush, 1);
`endif

    // Reset mid-stall and mid-halt.
    repeat (3) begin s.stall = 1; tick(); end
    async_reset();
    tick();
    rst_lvl = 1'b1;
    tick(); #3 check("reboot_pcin", PCin, RV); check("reboot_we", PCWrite, 1);
    s.hl = 1; tick();
    tick(); #3 check("halt2_halted", halted, 1);
    async_reset();
    tick();
    rst_lvl = 1'b1;
    tick();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      s.stall = ($urandom_range(0, 99) < 30);
      s.br    = ($urandom_range(0, 9) == 0);
      s.bt    = 16'($urandom);
      s.jp    = ($urandom_range(0, 9) == 0);
      s.jt    = 16'($urandom);
      s.hl    = ($urandom_range(0, 19) == 0);
      s.rs    = ($urandom_range(0, 3) == 0);
      s.tr    = ($urandom_range(0, 24) == 0);
      s.pc_en = ($urandom_range(0, 15) == 0);
      s.pc    = 16'($urandom);
      rst_lvl = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_lvl = 1'b1;
    repeat (2) tick();
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
